// File: rtl/case_label_stim_gen_pkg.sv
// Shared definitions for the case-label stimulus generator and its label ROM:
// class codes, label table constants, per-class label counts and FSM encoding.
package case_label_stim_gen_pkg;

  localparam logic [1:0] CLS0    = 2'd0;
  localparam logic [1:0] CLS1    = 2'd1;
  localparam logic [1:0] CLS2    = 2'd2;
  localparam logic [1:0] CLS_BAD = 2'd3;

  localparam logic [2:0] ALL_ONES = 3'b111;

  localparam logic [2:0] LBL_C0_0 = 3'b000;
  localparam logic [2:0] LBL_C0_1 = 3'b001;
  localparam logic [2:0] LBL_C1_0 = 3'b101;
  localparam logic [2:0] LBL_C2_0 = 3'b110;
  localparam logic [2:0] LBL_C2_1 = 3'b111;
  localparam logic [2:0] LBL_C2_2 = 3'b100;

  localparam logic [1:0] NUM_LBL_CLS0 = 2'd2;
  localparam logic [1:0] NUM_LBL_CLS1 = 2'd1;
  localparam logic [1:0] NUM_LBL_CLS2 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // The illegal class reports a single label so index 0 is always "last".
  function automatic logic [1:0] labelCount(input logic [1:0] cls);
    logic [1:0] n;
    case (cls)
      CLS0:    n = NUM_LBL_CLS0;
      CLS1:    n = NUM_LBL_CLS1;
      CLS2:    n = NUM_LBL_CLS2;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/case_label_rom.sv
// Combinational label table: (class, index) -> label, with a flag marking the
// final label of that class. Shared with the classifier's checker.
module case_label_rom
  import case_label_stim_gen_pkg::*;
(
  input  logic [1:0] cls_i,
  input  logic [1:0] idx_i,
  output logic [2:0] label_o,
  output logic       last_o
);

  always_comb begin
    label_o = 3'b000;
    case (cls_i)
      CLS0: label_o = (idx_i == 2'd0) ? LBL_C0_0 : LBL_C0_1;
      CLS1: label_o = LBL_C1_0;
      CLS2: begin
        case (idx_i)
          2'd0:    label_o = LBL_C2_0;
          2'd1:    label_o = LBL_C2_1;
          default: label_o = LBL_C2_2;
        endcase
      end
      default: label_o = 3'b000;
    endcase
    last_o = (idx_i == (labelCount(cls_i) - 2'd1));
  end

endmodule

// File: rtl/case_label_stim_gen.sv
// Operand-pair generator: accepts a class request and streams every (val1, val2)
// pair whose AND hits each label of that class, tagged with the expected class.
module case_label_stim_gen
  import case_label_stim_gen_pkg::*;
#(
  parameter bit          EMIT_SWAP = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       val1,
  output logic [2:0]       val2,
  output logic [1:0]       out_expect,
  output logic             out_last,
  output logic             req_err,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt
);

  state_t           state_q, state_d;
  logic [1:0]       cls_q, cls_d;
  logic [1:0]       idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             reqErr_q, reqErr_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

  logic [2:0] label;
  logic       lastLabel;
  logic       lastBeat;
  logic       outFire;

  case_label_rom uRom (
    .cls_i   (cls_q),
    .idx_i   (idx_q),
    .label_o (label),
    .last_o  (lastLabel)
  );

  assign lastBeat  = lastLabel && (!EMIT_SWAP || sub_q);
  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign outFire   = out_valid && out_ready;
  assign req_err   = reqErr_q;
  assign done      = done_q;
  assign beat_cnt  = beatCnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cls_q     <= CLS0;
      idx_q     <= 2'd0;
      sub_q     <= 1'b0;
      reqErr_q  <= 1'b0;
      done_q    <= 1'b0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      reqErr_q  <= reqErr_d;
      done_q    <= done_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // Beat payload comes straight from held registers, so it is stable under stall.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    idx_d      = idx_q;
    sub_d      = sub_q;
    reqErr_d   = 1'b0;
    done_d     = 1'b0;
    beatCnt_d  = beatCnt_q;
    val1       = 3'b000;
    val2       = 3'b000;
    out_expect = 2'd0;
    out_last   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_class == CLS_BAD) begin
            reqErr_d = 1'b1;
          end else begin
            cls_d   = req_class;
            idx_d   = 2'd0;
            sub_d   = 1'b0;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        val1       = sub_q ? ALL_ONES : label;
        val2       = sub_q ? label : ALL_ONES;
        out_expect = cls_q;
        out_last   = lastBeat;
        if (outFire) begin
          if (lastBeat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (EMIT_SWAP && !sub_q) begin
            sub_d = 1'b1;
          end else begin
            sub_d = 1'b0;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (outFire && (beatCnt_q != {CNT_W{1'b1}})) begin
      beatCnt_d = beatCnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_case_label_stim_gen.sv
// Directed bench for case_label_stim_gen: instance A uses defaults, instance B
// has EMIT_SWAP=0 and a 2-bit counter to reach saturation quickly.
module tb_case_label_stim_gen;

  typedef struct {
    logic [2:0] v1;
    logic [2:0] v2;
    logic [1:0] cls;
    logic       last;
  } beatVec_t;

  typedef struct {
    bit         sel;
    logic [1:0] cls;
    bit         stall;
    int         base;
    int         n;
    int         cntAfter;
  } reqVec_t;

  logic clk = 1'b0;
  logic reset;

  logic       aReqValid, aReqReady, aOutValid, aOutReady, aLast, aErr, aDone;
  logic [1:0] aReqClass, aExpect;
  logic [2:0] aVal1, aVal2;
  logic [7:0] aCnt;

  logic       bReqValid, bReqReady, bOutValid, bOutReady, bLast, bErr, bDone;
  logic [1:0] bReqClass, bExpect;
  logic [2:0] bVal1, bVal2;
  logic [1:0] bCnt;

  int vecCount  = 0;
  int missCount = 0;

  beatVec_t beats[17];
  reqVec_t  reqs[4];

  always #5 clk = ~clk;

  case_label_stim_gen dutA (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (aReqValid),
    .req_ready  (aReqReady),
    .req_class  (aReqClass),
    .out_valid  (aOutValid),
    .out_ready  (aOutReady),
    .val1       (aVal1),
    .val2       (aVal2),
    .out_expect (aExpect),
    .out_last   (aLast),
    .req_err    (aErr),
    .done       (aDone),
    .beat_cnt   (aCnt)
  );

  case_label_stim_gen #(.EMIT_SWAP(1'b0), .CNT_W(2)) dutB (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (bReqValid),
    .req_ready  (bReqReady),
    .req_class  (bReqClass),
    .out_valid  (bOutValid),
    .out_ready  (bOutReady),
    .val1       (bVal1),
    .val2       (bVal2),
    .out_expect (bExpect),
    .out_last   (bLast),
    .req_err    (bErr),
    .done       (bDone),
    .beat_cnt   (bCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int classify(input logic [2:0] v);
    int c;
    case (v)
      3'b000, 3'b001:         c = 0;
      3'b101:                 c = 1;
      3'b110, 3'b111, 3'b100: c = 2;
      default:                c = 3;
    endcase
    return c;
  endfunction

  task automatic sample(input bit sel, output logic v, output logic [2:0] p1, output logic [2:0] p2,
                        output logic [1:0] ex, output logic last, output logic rdy,
                        output logic err, output logic dn, output int cnt);
    v    = sel ? bOutValid : aOutValid;
    p1   = sel ? bVal1 : aVal1;
    p2   = sel ? bVal2 : aVal2;
    ex   = sel ? bExpect : aExpect;
    last = sel ? bLast : aLast;
    rdy  = sel ? bReqReady : aReqReady;
    err  = sel ? bErr : aErr;
    dn   = sel ? bDone : aDone;
    cnt  = sel ? int'(bCnt) : int'(aCnt);
  endtask

  task automatic setReady(input bit sel, input logic r);
    if (sel) bOutReady = r;
    else     aOutReady = r;
  endtask

  task automatic applyStimulus(input bit sel, input logic [1:0] cls);
    logic v, last, rdy, err, dn;
    logic [2:0] p1, p2;
    logic [1:0] ex;
    int cnt;
    sample(sel, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("req_ready_before_request", rdy, 1);
    if (sel) begin
      bReqValid = 1'b1;
      bReqClass = cls;
    end else begin
      aReqValid = 1'b1;
      aReqClass = cls;
    end
    tick();
    aReqValid = 1'b0;
    bReqValid = 1'b0;
  endtask

  // Ready pattern under stall is 1,0,0,1,0,0,...; a stalled beat must match the
  // same table entry on every cycle it is presented.
  task automatic collectBeats(input bit sel, input int base, input int n, input bit stall);
    logic v, last, rdy, err, dn, r;
    logic [2:0] p1, p2;
    logic [1:0] ex;
    int cnt;
    int k   = 0;
    int cyc = 0;
    while (k < n && cyc < 64) begin
      sample(sel, v, p1, p2, ex, last, rdy, err, dn, cnt);
      checkOutput("out_valid", v, 1);
      checkOutput("val1", p1, beats[base+k].v1);
      checkOutput("val2", p2, beats[base+k].v2);
      checkOutput("out_expect", ex, beats[base+k].cls);
      checkOutput("out_last", last, beats[base+k].last);
      checkOutput("classifier_vs_expect", classify(p1 & p2), ex);
      r = !stall || (cyc % 3 == 0);
      setReady(sel, r);
      tick();
      if (r) k++;
      cyc++;
    end
    if (k != n) checkOutput("beat_timeout", k, n);
    setReady(sel, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic v, last, rdy, err, dn;
    logic [2:0] p1, p2;
    logic [1:0] ex;
    int cnt;

    beats[0]  = '{3'b101, 3'b111, 2'd1, 1'b0};
    beats[1]  = '{3'b111, 3'b101, 2'd1, 1'b1};
    beats[2]  = '{3'b110, 3'b111, 2'd2, 1'b0};
    beats[3]  = '{3'b111, 3'b110, 2'd2, 1'b0};
    beats[4]  = '{3'b111, 3'b111, 2'd2, 1'b0};
    beats[5]  = '{3'b111, 3'b111, 2'd2, 1'b0};
    beats[6]  = '{3'b100, 3'b111, 2'd2, 1'b0};
    beats[7]  = '{3'b111, 3'b100, 2'd2, 1'b1};
    beats[8]  = '{3'b000, 3'b111, 2'd0, 1'b0};
    beats[9]  = '{3'b111, 3'b000, 2'd0, 1'b0};
    beats[10] = '{3'b001, 3'b111, 2'd0, 1'b0};
    beats[11] = '{3'b111, 3'b001, 2'd0, 1'b1};
    beats[12] = '{3'b110, 3'b111, 2'd2, 1'b0};
    beats[13] = '{3'b111, 3'b111, 2'd2, 1'b0};
    beats[14] = '{3'b100, 3'b111, 2'd2, 1'b1};
    beats[15] = '{3'b000, 3'b111, 2'd0, 1'b0};
    beats[16] = '{3'b001, 3'b111, 2'd0, 1'b1};

    reqs[0] = '{1'b0, 2'd1, 1'b0, 0,  2, 2};
    reqs[1] = '{1'b0, 2'd2, 1'b1, 2,  6, 8};
    reqs[2] = '{1'b1, 2'd2, 1'b0, 12, 3, 3};
    reqs[3] = '{1'b1, 2'd0, 1'b0, 15, 2, 3};

    reset     = 1'b1;
    aReqValid = 1'b0;
    aReqClass = 2'd0;
    aOutReady = 1'b0;
    bReqValid = 1'b0;
    bReqClass = 2'd0;
    bOutReady = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("rst_req_ready", rdy, 1);
    checkOutput("rst_out_valid", v, 0);
    checkOutput("rst_val1", p1, 0);
    checkOutput("rst_val2", p2, 0);
    checkOutput("rst_out_expect", ex, 0);
    checkOutput("rst_out_last", last, 0);
    checkOutput("rst_req_err", err, 0);
    checkOutput("rst_done", dn, 0);
    checkOutput("rst_beat_cnt", cnt, 0);
    sample(1'b1, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("rst_b_beat_cnt", cnt, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(reqs[i].sel, reqs[i].cls);
      collectBeats(reqs[i].sel, reqs[i].base, reqs[i].n, reqs[i].stall);
      sample(reqs[i].sel, v, p1, p2, ex, last, rdy, err, dn, cnt);
      checkOutput("done_pulse", dn, 1);
      checkOutput("post_out_valid", v, 0);
      checkOutput("post_req_ready", rdy, 1);
      checkOutput("post_beat_cnt", cnt, reqs[i].cntAfter);
      tick();
      sample(reqs[i].sel, v, p1, p2, ex, last, rdy, err, dn, cnt);
      checkOutput("done_one_cycle", dn, 0);
    end

    // Illegal class: one-cycle error pulse, no beats, counter untouched.
    applyStimulus(1'b0, 2'd3);
    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("bad_req_err", err, 1);
    checkOutput("bad_out_valid", v, 0);
    checkOutput("bad_req_ready", rdy, 1);
    tick();
    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("bad_req_err_cleared", err, 0);
    checkOutput("bad_out_valid_later", v, 0);
    checkOutput("bad_beat_cnt", cnt, 8);

    // Reset in the middle of a class-0 request abandons it without a done pulse.
    applyStimulus(1'b0, 2'd0);
    collectBeats(1'b0, 8, 2, 1'b0);
    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("mid_out_valid", v, 1);
    checkOutput("mid_val1", p1, 3'b001);
    checkOutput("mid_beat_cnt", cnt, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("abort_out_valid", v, 0);
    checkOutput("abort_req_ready", rdy, 1);
    checkOutput("abort_beat_cnt", cnt, 0);
    checkOutput("abort_done", dn, 0);
    checkOutput("abort_val1", p1, 0);
    tick();
    sample(1'b0, v, p1, p2, ex, last, rdy, err, dn, cnt);
    checkOutput("abort_no_done_later", dn, 0);
    checkOutput("abort_idle_valid", v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
